// File: rtl/hilo_seq_ctrl_if.sv
// ============================================================================
// Module      : hilo_seq_ctrl_if
// Description : Operand, result and HI/LO bus between the datapath and the
//               mul/div sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hilo_seq_ctrl_if;
  logic        start;
  logic        op_div;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] mul_result;
  logic [63:0] div_result;
  logic        hi_wr_en;
  logic        lo_wr_en;
  logic [31:0] wr_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  // Datapath side: issues operations, feeds array results, reads HI/LO.
  modport master (
    output start, op_div, a_in, b_in, mul_result, div_result,
           hi_wr_en, lo_wr_en, wr_data,
    input  op_a, op_b, hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  start, op_div, a_in, b_in, mul_result, div_result,
           hi_wr_en, lo_wr_en, wr_data,
    output op_a, op_b, hi_out, lo_out, busy, done, div_zero
  );
endinterface

`default_nettype wire

// File: rtl/hilo_seq_ctrl.sv
// ============================================================================
// Module      : hilo_seq_ctrl
// Description : Mul/div sequencer - registers operands, holds them for a
//               settle window, then captures the result into HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_seq_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  wire                   clk,
  input  wire                   clr_n,
  hilo_seq_ctrl_if.slave        bus
);

  localparam int c_cnt_w = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_capture;
  logic               w_div_by_zero;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_op_a;
  logic [31:0]        r_op_b;
  logic               r_op_div;
  logic               r_div_zero;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_div_by_zero = bus.op_div && (bus.b_in == 32'd0);
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_div_by_zero ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands stay frozen from accept until the next accept: the divider is a
  // multicycle path and relies on them not toggling during the settle window.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_op_a     <= 32'd0;
      r_op_b     <= 32'd0;
      r_op_div   <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_op_a     <= bus.a_in;
      r_op_b     <= bus.b_in;
      r_op_div   <= bus.op_div;
      r_div_zero <= w_div_by_zero;
      if (!w_div_by_zero) begin
        r_cnt <= c_cnt_load;
      end
    end else if (r_state == ST_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // The sequenced capture takes priority over a same-edge mthi/mtlo.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_capture) begin
      r_hi <= r_op_div ? bus.div_result[63:32] : bus.mul_result[63:32];
      r_lo <= r_op_div ? bus.div_result[31:0]  : bus.mul_result[31:0];
    end else begin
      if (bus.hi_wr_en) begin
        r_hi <= bus.wr_data;
      end
      if (bus.lo_wr_en) begin
        r_lo <= bus.wr_data;
      end
    end
  end

  assign bus.op_a     = r_op_a;
  assign bus.op_b     = r_op_b;
  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_hilo_seq_ctrl.sv
// ============================================================================
// Module      : tb_hilo_seq_ctrl
// Description : Directed self-checking bench for hilo_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_seq_ctrl;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_fails;
  int   lat;
  int   n_done;

  hilo_seq_ctrl_if bus ();

  hilo_seq_ctrl #(.SETTLE_CYCLES(4)) u_dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  // Combinational array models driven from the registered operands.
  assign bus.mul_result = {32'd0, bus.op_a} * {32'd0, bus.op_b};
  assign bus.div_result = (bus.op_b == 32'd0) ? 64'd0
                        : {bus.op_a % bus.op_b, bus.op_a / bus.op_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation (E0 is the first tick) and waits for done; lat counts
  // ticks after E0 until done is observed.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic div,
                        output int l);
    bus.a_in   = a;
    bus.b_in   = b;
    bus.op_div = div;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    l = 0;
    while (!bus.done && l < 20) begin
      tick();
      l++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clr_n        = 1'b0;
    bus.start    = 1'b0;
    bus.op_div   = 1'b0;
    bus.a_in     = 32'd0;
    bus.b_in     = 32'd0;
    bus.hi_wr_en = 1'b0;
    bus.lo_wr_en = 1'b0;
    bus.wr_data  = 32'd0;
    tick();
    tick();
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi",   {32'd0, bus.hi_out}, 64'd0);
    check("rst_lo",   {32'd0, bus.lo_out}, 64'd0);
    check("rst_op_a", {32'd0, bus.op_a}, 64'd0);
    check("rst_dz",   {63'd0, bus.div_zero}, 64'd0);
    clr_n = 1'b1;
    tick();

    // 1: 100 / 7 -> q=14, r=2
    bus.a_in = 32'd100; bus.b_in = 32'd7; bus.op_div = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t1_busy_e0", {63'd0, bus.busy}, 64'd1);
    lat = 0;
    while (!bus.done && lat < 20) begin tick(); lat++; end
    check("t1_lat", 64'(lat), 64'd4);
    check("t1_hi", {32'd0, bus.hi_out}, 64'd2);
    check("t1_lo", {32'd0, bus.lo_out}, 64'd14);
    tick();
    check("t1_done_pulse", {63'd0, bus.done}, 64'd0);
    check("t1_idle", {63'd0, bus.busy}, 64'd0);

    // 2: 0x10000 * 0x10000 = 0x1_0000_0000
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, lat);
    check("t2_lat", 64'(lat), 64'd4);
    check("t2_hi", {32'd0, bus.hi_out}, 64'd1);
    check("t2_lo", {32'd0, bus.lo_out}, 64'd0);
    check("t2_dz", {63'd0, bus.div_zero}, 64'd0);
    tick();

    // 3: preload, divide by zero, then multiply clears the flag
    bus.hi_wr_en = 1'b1; bus.lo_wr_en = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.hi_wr_en = 1'b0; bus.lo_wr_en = 1'b0;
    check("t3_pre_hi", {32'd0, bus.hi_out}, 64'hDEAD_BEEF);
    check("t3_pre_lo", {32'd0, bus.lo_out}, 64'hDEAD_BEEF);
    run_op(32'd55, 32'd0, 1'b1, lat);
    check("t3_dz_lat", 64'(lat), 64'd0);
    check("t3_dz_flag", {63'd0, bus.div_zero}, 64'd1);
    check("t3_dz_hi", {32'd0, bus.hi_out}, 64'hDEAD_BEEF);
    check("t3_dz_lo", {32'd0, bus.lo_out}, 64'hDEAD_BEEF);
    tick();
    bus.a_in = 32'd3; bus.b_in = 32'd5; bus.op_div = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t3_dz_clr", {63'd0, bus.div_zero}, 64'd0);
    lat = 0;
    while (!bus.done && lat < 20) begin tick(); lat++; end
    check("t3_mul_lat", 64'(lat), 64'd4);
    check("t3_mul_lo", {32'd0, bus.lo_out}, 64'd15);
    check("t3_mul_hi", {32'd0, bus.hi_out}, 64'd0);
    tick();

    // 4: starts during WAIT and DONE are ignored
    bus.a_in = 32'd10; bus.b_in = 32'd20; bus.op_div = 1'b0; bus.start = 1'b1;
    tick();
    bus.a_in = 32'd99; bus.b_in = 32'd98;
    tick();
    bus.start = 1'b0;
    check("t4_wait_op_a", {32'd0, bus.op_a}, 64'd10);
    lat = 0;
    while (!bus.done && lat < 20) begin tick(); lat++; end
    check("t4_lat", 64'(lat), 64'd3);
    check("t4_lo", {32'd0, bus.lo_out}, 64'd200);
    bus.a_in = 32'd77; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t4_done_op_a", {32'd0, bus.op_a}, 64'd10);
    check("t4_done_op_b", {32'd0, bus.op_b}, 64'd20);
    check("t4_no_busy", {63'd0, bus.busy}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    check("t4_extra_done", 64'(n_done), 64'd0);

    // 5: async reset mid-WAIT aborts
    bus.a_in = 32'd40; bus.b_in = 32'd3; bus.op_div = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    clr_n = 1'b0;
    #1;
    check("t5_busy", {63'd0, bus.busy}, 64'd0);
    check("t5_hi", {32'd0, bus.hi_out}, 64'd0);
    check("t5_lo", {32'd0, bus.lo_out}, 64'd0);
    check("t5_op_a", {32'd0, bus.op_a}, 64'd0);
    tick();
    clr_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    check("t5_no_done", 64'(n_done), 64'd0);

    // 6: direct write in IDLE lands; same write on the capture edge is dropped
    bus.hi_wr_en = 1'b1; bus.wr_data = 32'h1234;
    tick();
    bus.hi_wr_en = 1'b0;
    check("t6_idle_wr", {32'd0, bus.hi_out}, 64'h1234);
    bus.a_in = 32'h0001_0000; bus.b_in = 32'h0003_0000; bus.op_div = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("t6_pre_cap_hi", {32'd0, bus.hi_out}, 64'h1234);
    bus.hi_wr_en = 1'b1; bus.wr_data = 32'h1234;
    tick();
    bus.hi_wr_en = 1'b0;
    check("t6_cap_done", {63'd0, bus.done}, 64'd1);
    check("t6_cap_hi", {32'd0, bus.hi_out}, 64'd3);
    check("t6_cap_lo", {32'd0, bus.lo_out}, 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
